// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
//   word_t        : 32-bit register data word
//   regbits_t     : register select (5 bits, 32 registers)
//   rfarb_state_t : arbiter / clear-sweep sequencer state
package rf_write_arbiter_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned RF_SELW = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [RF_SELW-1:0] regbits_t;

  // Explicit encodings keep the state values stable for legacy consumers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } rfarb_state_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans i_valid starting at i_ptr, wrapping modulo NREQ, and grants the first
// requester found.
//   i_valid : request vector
//   i_ptr   : highest-priority index this cycle (must be < NREQ)
//   o_grant : one-hot grant (all zero when nothing is valid)
//   o_idx   : encoded winner index (0 when nothing is valid)
//   o_any   : a grant was issued
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Outer loop walks priority order; inner loop uses constant indices so the
    // candidate position is matched by comparison rather than a variable select.
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && i_valid[j] && (j == ((int'(i_ptr) + k) % NREQ))) begin
          o_any      = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with clear sequencer.
// Shares the single register-file write port between NREQ writeback sources
// using round-robin arbitration, and can sweep registers 1..2**SELW-1 to zero.
//   CLK, RST             : clock, synchronous active-high reset
//   req_valid/sel/dat    : per-requester write (sel/dat packed, slice i)
//   req_ready            : one-hot combinational grant
//   clr_start            : pulse to start a clear sweep (IDLE only)
//   clr_busy, clr_done   : sweep in progress / sweep-complete pulse
//   WEN, wsel, wdat      : registered register-file write port
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int SELW = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SELW-1:0] req_sel,
  input  logic [NREQ*32-1:0]   req_dat,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 WEN,
  output logic [SELW-1:0]      wsel,
  output logic [31:0]          wdat
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  rfarb_state_t    r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [SELW-1:0] r_sweep_idx;
  logic            r_wen;
  logic [SELW-1:0] r_wsel;
  word_t           r_wdat;

  logic [NREQ-1:0] w_arb_valid;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [SELW-1:0] w_sel;
  word_t           w_dat;
  logic [PW-1:0]   w_ptr_next;
  logic            w_sweep_last;

  // Requests are only visible to the arbiter in IDLE, and a clear request or
  // reset masks them so no handshake can complete that cycle.
  always_comb begin
    w_arb_valid = '0;
    if ((r_state == IDLE) && !clr_start && !RST) begin
      w_arb_valid = req_valid;
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .i_valid (w_arb_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;

  // One-hot mux of the winning requester's destination and data.
  always_comb begin
    w_sel = '0;
    w_dat = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_sel = req_sel[j*SELW +: SELW];
        w_dat = req_dat[j*32 +: 32];
      end
    end
  end

  // Explicit wrap: NREQ need not be a power of two.
  assign w_ptr_next = (w_idx == PW'(NREQ - 1)) ? '0 : (w_idx + PW'(1));

  // The sweep register issued last is all-ones; the output stage holds it.
  assign w_sweep_last = (r_wsel == '1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_sweep_idx <= SELW'(1);
      r_wen       <= 1'b0;
      r_wsel      <= '0;
      r_wdat      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            // First sweep write is issued on the same edge that enters SWEEP,
            // so the write port shows r1 in the first SWEEP cycle.
            r_state     <= SWEEP;
            r_wen       <= 1'b1;
            r_wsel      <= r_sweep_idx;
            r_wdat      <= '0;
            r_sweep_idx <= r_sweep_idx + SELW'(1);
          end else if (w_any) begin
            r_rr_ptr <= w_ptr_next;
            // Register 0 is hard-wired: the handshake completes but no write.
            if (w_sel != '0) begin
              r_wen  <= 1'b1;
              r_wsel <= w_sel;
              r_wdat <= w_dat;
            end else begin
              r_wen <= 1'b0;
            end
          end else begin
            r_wen <= 1'b0;
          end
        end
        SWEEP: begin
          if (w_sweep_last) begin
            r_state <= DONE;
            r_wen   <= 1'b0;
          end else begin
            r_wen       <= 1'b1;
            r_wsel      <= r_sweep_idx;
            r_wdat      <= '0;
            r_sweep_idx <= r_sweep_idx + SELW'(1);
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_wen       <= 1'b0;
          r_sweep_idx <= SELW'(1);
        end
        default: begin
          r_state <= IDLE;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = (r_state != IDLE);
  assign clr_done = (r_state == DONE);
  assign WEN      = r_wen;
  assign wsel     = r_wsel;
  assign wdat     = r_wdat;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int SELW = 5;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NREQ-1:0]      req_valid = '1;
  logic [NREQ*SELW-1:0] req_sel = '0;
  logic [NREQ*32-1:0]   req_dat = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 clr_start = 1'b0;
  logic                 clr_busy;
  logic                 clr_done;
  logic                 WEN;
  logic [SELW-1:0]      wsel;
  logic [31:0]          wdat;

  int n_tests = 0;
  int n_fail  = 0;

  // Register file model driven by the write port.
  logic [31:0] rf [32] = '{default: 32'h0};

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WEN === 1'b1) rf[wsel] <= wdat;
  end

  rf_write_arbiter #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_dat   (req_dat),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .WEN       (WEN),
    .wsel      (wsel),
    .wdat      (wdat)
  );

  // Positions just after the falling edge; caller drives inputs, waits #1,
  // then checks (well before the next rising edge).
  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      n_tests++;
      if (req_ready !== 3'b000) begin
        n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready);
      end
      n_tests++;
      if ({WEN, clr_busy, clr_done} !== 3'b000) begin
        n_fail++; $display("FAIL reset_ctl: got WEN/busy/done %b want 000",
                           {WEN, clr_busy, clr_done});
      end
      n_tests++;
      if ({wsel, wdat} !== '0) begin
        n_fail++; $display("FAIL reset_port: got wsel %0d wdat %h want 0", wsel, wdat);
      end
    end
    RST = 1'b0;
    req_valid = '0;
    next_cycle();
    #1;
    n_tests++;
    if ({WEN, clr_busy, req_ready} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_after: got WEN %b busy %b ready %b want 0/0/000",
                         WEN, clr_busy, req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] dats [3];
    dats[0] = 32'hAAAA_0001; dats[1] = 32'hBBBB_0002; dats[2] = 32'hCCCC_0003;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      req_valid = 3'b111;
      req_sel   = {5'd5, 5'd4, 5'd3};
      req_dat   = {dats[2], dats[1], dats[0]};
      #1;
      n_tests++;
      if (req_ready !== (3'b001 << (k % 3))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 3'b001 << (k % 3));
      end
      if (k > 0) begin
        n_tests++;
        if (WEN !== 1'b1 || wsel !== SELW'(3 + (k - 1) % 3) || wdat !== dats[(k - 1) % 3]) begin
          n_fail++; $display("FAIL rr_write[%0d]: got WEN %b sel %0d dat %h want 1 %0d %h",
                             k, WEN, wsel, wdat, 3 + (k - 1) % 3, dats[(k - 1) % 3]);
        end
      end
    end
    next_cycle();
    req_valid = '0;
    #1;
    n_tests++;
    if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== dats[2] || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL rr_last: got WEN %b sel %0d dat %h ready %b want 1 5 %h 000",
                         WEN, wsel, wdat, req_ready, dats[2]);
    end
    next_cycle();
    #1;
    n_tests++;
    if (WEN !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle: got WEN %b want 0", WEN);
    end
    n_tests++;
    if (rf[3] !== dats[0] || rf[4] !== dats[1] || rf[5] !== dats[2]) begin
      n_fail++; $display("FAIL rr_rf: got r3 %h r4 %h r5 %h", rf[3], rf[4], rf[5]);
    end
  endtask

  task automatic test_reg0();
    next_cycle();
    req_valid = 3'b010;
    req_sel   = {5'd9, 5'd0, 5'd8};
    req_dat   = {32'h99, 32'h0D, 32'h88};
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL r0_grant: got %b want 010", req_ready);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b0 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL r0_suppress: got WEN %b ready %b want 0 000", WEN, req_ready);
    end
    next_cycle();
    req_valid = 3'b101;
    #1;
    n_tests++;
    if (req_ready !== 3'b100) begin
      n_fail++; $display("FAIL r0_ptr: got %b want 100", req_ready);
    end
    next_cycle();
    req_valid = 3'b001;
    #1;
    n_tests++;
    if (req_ready !== 3'b001 || WEN !== 1'b1 || wsel !== 5'd9 || wdat !== 32'h99) begin
      n_fail++; $display("FAIL r0_next: got ready %b WEN %b sel %0d dat %h want 001 1 9 99",
                         req_ready, WEN, wsel, wdat);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b1 || wsel !== 5'd8 || wdat !== 32'h88) begin
      n_fail++; $display("FAIL r0_after: got WEN %b sel %0d dat %h want 1 8 88", WEN, wsel, wdat);
    end
  endtask

  // rr_ptr is 1 on entry; the post-sweep grant must honour it.
  task automatic test_sweep();
    int bad;
    next_cycle();
    req_valid = 3'b011;
    req_sel   = {5'd9, 5'd12, 5'd8};
    req_dat   = {32'h99, 32'hCC, 32'h88};
    clr_start = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 3'b000 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL sw_start: got ready %b busy %b want 000 0", req_ready, clr_busy);
    end
    for (int k = 1; k <= 31; k++) begin
      next_cycle();
      clr_start = (k == 5);  // ignored while sweeping
      #1;
      n_tests++;
      if (WEN !== 1'b1 || wsel !== SELW'(k) || wdat !== 32'h0 || req_ready !== 3'b000 ||
          clr_busy !== 1'b1 || clr_done !== 1'b0) begin
        n_fail++; $display("FAIL sw_write[%0d]: got WEN %b sel %0d dat %h ready %b busy %b done %b",
                           k, WEN, wsel, wdat, req_ready, clr_busy, clr_done);
      end
    end
    next_cycle();
    clr_start = 1'b0;
    #1;
    n_tests++;
    if (WEN !== 1'b0 || clr_done !== 1'b1 || clr_busy !== 1'b1 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL sw_done: got WEN %b done %b busy %b ready %b want 0 1 1 000",
                         WEN, clr_done, clr_busy, req_ready);
    end
    bad = 0;
    for (int r = 1; r < 32; r++) if (rf[r] !== 32'h0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL sw_rf: got %0d nonzero registers want 0", bad);
    end
    next_cycle();
    #1;
    n_tests++;
    if (req_ready !== 3'b010 || clr_done !== 1'b0 || clr_busy !== 1'b0 || WEN !== 1'b0) begin
      n_fail++; $display("FAIL sw_resume: got ready %b done %b busy %b WEN %b want 010 0 0 0",
                         req_ready, clr_done, clr_busy, WEN);
    end
    next_cycle();
    req_valid = 3'b001;
    #1;
    n_tests++;
    if (req_ready !== 3'b001 || WEN !== 1'b1 || wsel !== 5'd12 || wdat !== 32'hCC) begin
      n_fail++; $display("FAIL sw_grant: got ready %b WEN %b sel %0d dat %h want 001 1 12 cc",
                         req_ready, WEN, wsel, wdat);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b1 || wsel !== 5'd8) begin
      n_fail++; $display("FAIL sw_grant2: got WEN %b sel %0d want 1 8", WEN, wsel);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    next_cycle();
    clr_start = 1'b1;
    #1;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      clr_start = 1'b0;
      #1;
      n_tests++;
      if (WEN !== 1'b1 || wsel !== SELW'(k)) begin
        n_fail++; $display("FAIL mr_write[%0d]: got WEN %b sel %0d", k, WEN, wsel);
      end
    end
    next_cycle();
    RST = 1'b1;
    req_valid = 3'b001;
    #1;
    n_tests++;
    if (req_ready !== 3'b000) begin
      n_fail++; $display("FAIL mr_ready: got %b want 000", req_ready);
    end
    next_cycle();
    RST = 1'b0;
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++; $display("FAIL mr_abort: got WEN %b busy %b done %b want 0 0 0",
                         WEN, clr_busy, clr_done);
    end
    bad = 0;
    for (int c = 0; c < 35; c++) begin
      next_cycle();
      #1;
      if (WEN !== 1'b0 || clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mr_quiet: got %0d active cycles want 0", bad);
    end
    next_cycle();
    req_valid = 3'b011;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL mr_grant: got %b want 001", req_ready);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b1 || wsel !== 5'd8 || wdat !== 32'h88) begin
      n_fail++; $display("FAIL mr_write: got WEN %b sel %0d dat %h want 1 8 88", WEN, wsel, wdat);
    end
  endtask

  // rr_ptr is 1 on entry; one grant to req 1 moves it to 2.
  task automatic test_same_dest();
    next_cycle();
    req_valid = 3'b010;
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL sd_setup: got %b want 010", req_ready);
    end
    next_cycle();
    req_valid = 3'b101;
    req_sel   = {5'd7, 5'd12, 5'd7};
    req_dat   = {32'h22, 32'hCC, 32'h11};
    #1;
    n_tests++;
    if (req_ready !== 3'b100) begin
      n_fail++; $display("FAIL sd_first: got %b want 100", req_ready);
    end
    next_cycle();
    req_valid = 3'b001;
    #1;
    n_tests++;
    if (req_ready !== 3'b001 || WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h22) begin
      n_fail++; $display("FAIL sd_w1: got ready %b WEN %b sel %0d dat %h want 001 1 7 22",
                         req_ready, WEN, wsel, wdat);
    end
    next_cycle();
    req_valid = 3'b000;
    #1;
    n_tests++;
    if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h11) begin
      n_fail++; $display("FAIL sd_w2: got WEN %b sel %0d dat %h want 1 7 11", WEN, wsel, wdat);
    end
    next_cycle();
    #1;
    n_tests++;
    if (rf[7] !== 32'h11 || WEN !== 1'b0) begin
      n_fail++; $display("FAIL sd_rf: got r7 %h WEN %b want 11 0", rf[7], WEN);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reg0();
    test_sweep();
    test_reset_mid_sweep();
    test_same_dest();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between NREQ writeback sources, for example the ALU, load return and multiply/divide units.
- Uses round-robin arbitration with a valid/ready handshake per source.
- Registers the winning write into a one-cycle output stage that drives the register file WEN/wsel/wdat.
- Contains a clear sequencer that sweeps registers 1..31 to zero on command. Writes to register 0 are accepted and discarded.

Parameters:
NREQ, 3, number of write requesters (2..8).
SELW, 5, register select width; register count is 2**SELW = 32.

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
req_valid  input  NREQ  requester i holds a write.
req_sel  input  NREQ*SELW  requester i destination; slice [i*SELW +: SELW].
req_dat  input  NREQ*32  requester i data (word_t); slice [i*32 +: 32].
req_ready  output  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
clr_start  input  1  single-cycle pulse requesting a register clear sweep.
clr_busy  output  1  high while the sweep is in progress (SWEEP and DONE states).
clr_done  output  1  single-cycle pulse when the sweep completes.
WEN  output  1  register file write enable.
wsel  output  SELW  register file write select.
wdat  output  32  register file write data.

Behaviour:
Reset (RST high at a rising edge):
- WEN=0, wsel=0, wdat=0, clr_busy=0, clr_done=0.
- rr_ptr=0, sweep_idx=1, state=IDLE.
- req_ready is combinationally 0 while RST is high.

States: IDLE, SWEEP, DONE (rfarb_state_t).

IDLE, arbitration:
- The winner is the first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
- req_ready is combinational and one-hot on the winner; it is all-zero when no source is valid or when clr_start=1.
- On a transfer, the next edge loads WEN=1, wsel=req_sel[w], wdat=req_dat[w], and sets rr_ptr=(w+1) mod NREQ.
- With no transfer: WEN=0 next cycle, rr_ptr unchanged, wsel/wdat hold their last values.
- Latency is exactly 1 cycle from handshake to WEN. Throughput is 1 write per cycle.
- A requester holds valid/sel/dat stable until ready; the arbiter never drops a granted write.

Register 0:
- A granted write with req_sel=0 completes its handshake and advances rr_ptr.
- WEN stays 0 for that slot.

Same-destination conflict:
- No merging. Writes retire in grant order, and the later grant's data is what remains in the register file.

Clear sweep:
- clr_start=1 in IDLE takes priority over requests: req_ready=0 that cycle and the next state is SWEEP, with clr_busy=1 from the next cycle.
- SWEEP: req_ready=0. Each cycle the output stage loads WEN=1, wsel=sweep_idx, wdat=0, then sweep_idx increments.
- After sweep_idx=31 is issued, the next state is DONE.
- Register 0 is never written by the sweep; the sweep issues 31 writes over 31 consecutive cycles.
- DONE (1 cycle): WEN=0, clr_done=1, clr_busy=1, sweep_idx reset to 1; the next state is IDLE.
- clr_start is ignored in SWEEP and DONE. rr_ptr is preserved across a sweep.

Reset mid-sweep: the sweep aborts immediately, and no further sweep writes or clr_done pulse occur.

Width rules: sweep_idx is SELW bits; rr_ptr is $clog2(NREQ) bits with explicit wrap at NREQ-1 (not a power-of-two wrap).

Decomposition:
Add to cpu_types_pkg:
- regbits_t (logic [SELW-1:0]).
- rfarb_state_t enum {IDLE, SWEEP, DONE}.
- Reuse word_t for data.

Sub-module rr_arbiter, parameterised by NREQ:
- Inputs: valid vector and rr_ptr.
- Outputs: one-hot grant and encoded winner index.
- Purely combinational.
The pointer register and output stage stay in rf_write_arbiter.

Test Plan:
1. Reset behaviour: hold RST for 2 cycles with all req_valid=1 -> req_ready=000, WEN=0, clr_busy=0 during and on the first cycle after.
2. Round-robin rotation: all three valid continuously (sel 3/4/5, dat A/B/C) -> grants 0,1,2,0,...; WEN writes r3=A, r4=B, r5=C with 1-cycle lag, one per cycle.
3. Register-0 suppression: only req 1 valid with sel=0 -> req_ready=010 for one cycle, next cycle WEN=0, rr_ptr=2; then req 0 and req 2 valid -> req 2 granted first.
4. Clear sweep with a collision: clr_start pulsed with req 0 valid in the same cycle -> req_ready=000; 31 cycles WEN=1 wsel=1..31 wdat=0; then clr_done=1 for one cycle; req 0 granted the cycle after.
5. Reset mid-sweep: RST asserted after sweep writes to r1..r10 -> WEN=0, no clr_done, IDLE; a subsequent request is granted normally.
6. Same-destination ordering: req 0 and req 2 both write r7 (0x11, 0x22), rr_ptr=2 -> 0x22 written first, then 0x11; register file read of r7 returns 0x11.
